// File: rtl/spi_init_sequencer.sv
// rtl/spi_init_sequencer.sv - bit-serial SPI master stepping the init message table (option: SPI_SEQ_AUTOSTART_EN)
module spi_init_sequencer #(
    parameter int CLK_DIV    = 2,
    parameter int GAP_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic start,
    input  logic msg_bit,
    input  logic last_bit,
    input  logic last_msg,
    output logic inc_bit,
    output logic inc_msg,
    output logic sclk,
    output logic sdata,
    output logic cs_n,
    output logic busy,
    output logic done
);

    // Counter reload values: each state lasts (reload + 1) cycles.
    localparam logic [7:0] LP_DIV_M1 = 8'(CLK_DIV - 1);
    localparam logic [7:0] LP_GAP_M1 = 8'(GAP_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOW,
        S_HIGH,
        S_HOLD,
        S_GAP
    } state_t;

    state_t     r_state;
    state_t     w_state_nx;
    logic [7:0] r_cnt;
    logic [7:0] w_cnt_nx;
    logic       r_bit_last;
    logic       r_msg_last;
    logic       r_sclk;
    logic       r_sdata;
    logic       r_cs_n;
    logic       r_busy;
    logic       r_done;
    logic       w_start;
    logic       w_start_acc;
    logic       w_cnt_zero;
    logic       w_high_first;
    logic       w_bit_last;
    logic       w_inc_bit;
    logic       w_inc_msg;
    logic       w_load_sdata;
    logic       w_set_done;

`ifdef SPI_SEQ_AUTOSTART_EN
    logic r_auto_pend;

    // Trails reset by one cycle so the first cycle after release looks like a start pulse
    always_ff @(posedge clock) begin
        r_auto_pend <= reset;
    end

    assign w_start = start | r_auto_pend;
`else
    assign w_start = start;
`endif

    assign w_start_acc  = (r_state == S_IDLE) && w_start;
    assign w_cnt_zero   = (r_cnt == 8'd0);
    assign w_high_first = (r_state == S_HIGH) && (r_cnt == LP_DIV_M1);
    // With CLK_DIV=1 the first HIGH cycle is also the last, so the flag is not latched yet.
    assign w_bit_last   = w_high_first ? last_bit : r_bit_last;

    // State register and shared down-counter
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= 8'd0;
        end else begin
            r_state <= w_state_nx;
            r_cnt   <= w_cnt_nx;
        end
    end

    // Next-state, counter reload and table-stepping pulses
    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt - 8'd1;
        w_inc_bit    = 1'b0;
        w_inc_msg    = 1'b0;
        w_load_sdata = 1'b0;
        w_set_done   = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_cnt_nx = 8'd0;
                if (w_start) begin
                    w_state_nx   = S_LOW;
                    w_cnt_nx     = LP_DIV_M1;
                    w_load_sdata = 1'b1;
                end
            end
            S_LOW: begin
                if (w_cnt_zero) begin
                    w_state_nx = S_HIGH;
                    w_cnt_nx   = LP_DIV_M1;
                end
            end
            S_HIGH: begin
                w_inc_bit = w_high_first;
                if (w_cnt_zero) begin
                    w_cnt_nx = LP_DIV_M1;
                    if (w_bit_last) begin
                        w_state_nx = S_HOLD;
                    end else begin
                        w_state_nx   = S_LOW;
                        w_load_sdata = 1'b1;
                    end
                end
            end
            S_HOLD: begin
                if (w_cnt_zero) begin
                    w_inc_msg  = 1'b1;
                    w_state_nx = S_GAP;
                    w_cnt_nx   = LP_GAP_M1;
                end
            end
            S_GAP: begin
                if (w_cnt_zero) begin
                    if (r_msg_last) begin
                        w_state_nx = S_IDLE;
                        w_cnt_nx   = 8'd0;
                        w_set_done = 1'b1;
                    end else begin
                        w_state_nx   = S_LOW;
                        w_cnt_nx     = LP_DIV_M1;
                        w_load_sdata = 1'b1;
                    end
                end
            end
            default: begin
                w_state_nx = S_IDLE;
                w_cnt_nx   = 8'd0;
            end
        endcase
    end

    // Registered pins and table-end flags; pins follow the state being entered
    always_ff @(posedge clock) begin
        if (reset) begin
            r_bit_last <= 1'b0;
            r_msg_last <= 1'b0;
            r_sdata    <= 1'b0;
            r_sclk     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            if (w_high_first) begin
                r_bit_last <= last_bit;
            end
            if (w_inc_msg) begin
                r_msg_last <= last_msg;
            end
            if (w_load_sdata) begin
                r_sdata <= msg_bit;
            end
            r_sclk <= (w_state_nx == S_HIGH);
            r_cs_n <= (w_state_nx == S_IDLE) || (w_state_nx == S_GAP);
            r_busy <= (w_state_nx != S_IDLE);
            if (w_start_acc) begin
                r_done <= 1'b0;
            end else if (w_set_done) begin
                r_done <= 1'b1;
            end
        end
    end

    assign inc_bit = w_inc_bit;
    assign inc_msg = w_inc_msg;
    assign sclk    = r_sclk;
    assign sdata   = r_sdata;
    assign cs_n    = r_cs_n;
    assign busy    = r_busy;
    assign done    = r_done;

endmodule
